// File: rtl/mem_arbiter.sv
// Single-port block RAM arbiter between the core memory interface and a
// debug/program-loader port. Round-robin on contention, a debug lock that
// holds the core off for multi-access sequences, and one-cycle read return.
//
// state  | meaning
// ARB    | round-robin arbitration between core and debug
// LOCKED | debug owns the RAM; core grants suppressed until d_lock drops
module mem_arbiter #(
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [31:0]       c_wdata,
   input  logic [3:0]        c_wmask,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [31:0]       c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_wmask,
   input  logic              d_lock,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-3:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [CNT_W-1:0]  conflicts
);

   typedef enum logic {ARB, LOCKED} state_t;

   state_t            state, state_nxt;
   logic              last_owner;
   logic              rd_pend;
   logic              rd_tag;
   logic              gnt_we;
   logic [CNT_W-1:0]  cnt;

   // byte offset bits are not used for word addressing
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{c_addr[1:0], d_addr[1:0]};

   // grant decision and next state; grants held low while reset is asserted
   always_comb begin
      c_gnt     = 1'b0;
      d_gnt     = 1'b0;
      state_nxt = state;
      if (reset_n) begin
         if (state == LOCKED) begin
            d_gnt = d_req;
            if (!d_lock) state_nxt = ARB;
         end else begin
            if (c_req && d_req) begin
               if (last_owner) c_gnt = 1'b1;
               else            d_gnt = 1'b1;
            end else begin
               c_gnt = c_req;
               d_gnt = d_req;
            end
            if (d_gnt && d_lock) state_nxt = LOCKED;
         end
      end
   end

   // RAM port drive from whichever requester won this cycle
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 4'h0;
      ram_addr  = '0;
      ram_wdata = 32'h0;
      gnt_we    = 1'b0;
      if (c_gnt) begin
         ram_en    = 1'b1;
         ram_addr  = c_addr[ADDR_W-1:2];
         ram_wdata = c_wdata;
         gnt_we    = c_we;
         ram_we    = c_we ? c_wmask : 4'h0;
      end else if (d_gnt) begin
         ram_en    = 1'b1;
         ram_addr  = d_addr[ADDR_W-1:2];
         ram_wdata = d_wdata;
         gnt_we    = d_we;
         ram_we    = d_we ? d_wmask : 4'h0;
      end
   end

   // FSM state and round-robin history
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ARB;
         last_owner <= 1'b1;
      end else begin
         state <= state_nxt;
         if (c_gnt)      last_owner <= 1'b0;
         else if (d_gnt) last_owner <= 1'b1;
      end
   end

   // pending read tracking; the RAM output lands one cycle after the grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend <= 1'b0;
         rd_tag  <= 1'b0;
      end else begin
         rd_pend <= (c_gnt || d_gnt) && !gnt_we;
         if (c_gnt || d_gnt) rd_tag <= d_gnt;
      end
   end

   // saturating count of cycles where both ports asked for the RAM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (c_req && d_req && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign c_rvalid  = rd_pend && !rd_tag;
   assign d_rvalid  = rd_pend && rd_tag;
   assign c_rdata   = ram_rdata;
   assign d_rdata   = ram_rdata;
   assign conflicts = cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked against a behavioural model of the arbitration rules.
module tb_mem_arbiter;

   localparam int AW = 14;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          c_req, c_we, d_req, d_we, d_lock;
   logic [AW-1:0] c_addr, d_addr;
   logic [31:0]   c_wdata, d_wdata, ram_rdata;
   logic [3:0]    c_wmask, d_wmask;
   logic          c_gnt, c_rvalid, d_gnt, d_rvalid, ram_en;
   logic [31:0]   c_rdata, d_rdata, ram_wdata;
   logic [3:0]    ram_we;
   logic [AW-3:0] ram_addr;
   logic [CW-1:0] conflicts;

   mem_arbiter #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wmask(c_wmask),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .conflicts(conflicts)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: who owned the RAM last, whether debug holds the lock,
   // the read (if any) whose data is due next cycle, and the tie count
   bit m_last_dbg, m_locked, m_pend, m_pend_dbg;
   int m_conf;
   bit e_c, e_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last_dbg = 1'b1;
      m_locked   = 1'b0;
      m_pend     = 1'b0;
      m_pend_dbg = 1'b0;
      m_conf     = 0;
   endtask

   task automatic idle_inputs();
      c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_wmask = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
      d_lock = 0;
   endtask

   // one clock cycle: check combinational outputs at the falling edge,
   // then advance the model across the rising edge
   task automatic step();
      logic [31:0] x_addr, x_wdata;
      logic [3:0]  x_we;
      bit          g_we;
      @(negedge clk);
      if (m_locked) begin
         e_d = d_req;
         e_c = 1'b0;
      end else if (c_req && d_req) begin
         e_c = m_last_dbg;
         e_d = !m_last_dbg;
      end else begin
         e_c = c_req;
         e_d = d_req;
      end
      g_we    = e_c ? c_we : (e_d ? d_we : 1'b0);
      x_addr  = e_c ? 32'(c_addr) / 4 : (e_d ? 32'(d_addr) / 4 : 32'h0);
      x_we    = !g_we ? 4'h0 : (e_c ? c_wmask : d_wmask);
      x_wdata = e_c ? c_wdata : d_wdata;
      chk("c_gnt", 32'(c_gnt), 32'(e_c));
      chk("d_gnt", 32'(d_gnt), 32'(e_d));
      chk("gnt_excl", 32'(c_gnt & d_gnt), 32'h0);
      chk("ram_en", 32'(ram_en), 32'(e_c | e_d));
      chk("ram_addr", 32'(ram_addr), x_addr);
      chk("ram_we", 32'(ram_we), 32'(x_we));
      if (!(e_c || e_d)) chk("ram_wdata_idle", ram_wdata, 32'h0);
      else if (g_we)     chk("ram_wdata", ram_wdata, x_wdata);
      chk("c_rvalid", 32'(c_rvalid), 32'(m_pend && !m_pend_dbg));
      chk("d_rvalid", 32'(d_rvalid), 32'(m_pend && m_pend_dbg));
      if (m_pend && !m_pend_dbg) chk("c_rdata", c_rdata, ram_rdata);
      if (m_pend && m_pend_dbg)  chk("d_rdata", d_rdata, ram_rdata);
      chk("conflicts", 32'(conflicts), 32'(m_conf));
      @(posedge clk);
      if (c_req && d_req && m_conf < 15) m_conf++;
      m_pend = (e_c || e_d) && !g_we;
      if (e_c || e_d) begin
         m_pend_dbg = e_d;
         m_last_dbg = e_d;
      end
      if (m_locked) m_locked = d_lock;
      else          m_locked = e_d && d_lock;
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ram_en", 32'(ram_en), 32'h0);
      chk("rst_rvalid", 32'({c_rvalid, d_rvalid}), 32'h0);
      chk("rst_conflicts", 32'(conflicts), 32'h0);
      reset_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit c_hold, d_hold;
      ram_rdata = 32'h0;
      do_reset();

      // core-only read, data returned next cycle
      c_req = 1; c_we = 0; c_addr = 14'h0010;
      step();
      chk("t1_gnt_addr", 32'(ram_addr), 32'h004);
      c_req = 0; ram_rdata = 32'hDEADBEEF;
      step();
      chk("t1_rdata", c_rdata, 32'hDEADBEEF);

      // contention after reset alternates starting with the core
      do_reset();
      c_req = 1; d_req = 1; c_addr = 14'h0040; d_addr = 14'h0080; c_we = 1; d_we = 1;
      c_wmask = 4'h3; d_wmask = 4'hC; c_wdata = 32'h11112222; d_wdata = 32'h33334444;
      repeat (4) step();
      idle_inputs();
      step();
      chk("t2_conflicts", 32'(conflicts), 32'h4);

      // debug lock holds the core off, one extra locked cycle after release
      d_req = 1; d_we = 1; d_addr = 14'h0100; d_wmask = 4'hF; d_wdata = 32'h12345678; d_lock = 1;
      step();
      c_req = 1; c_we = 0; c_addr = 14'h0200; d_we = 0;
      repeat (3) step();
      d_lock = 0;
      step();
      step();
      chk("t3_core_after_unlock", 32'(e_c), 32'h1);
      idle_inputs();

      // back-to-back reads from alternating owners
      c_req = 1; c_addr = 14'h0024;
      step();
      c_req = 0; d_req = 1; d_addr = 14'h0028; ram_rdata = 32'hA5A5A5A5;
      step();
      d_req = 0; ram_rdata = 32'h5A5A5A5A;
      step();
      step();

      // reset while a core read is in flight
      c_req = 1; c_we = 0; c_addr = 14'h0030; d_req = 1;
      @(negedge clk);
      chk("t5_gnt_before_rst", 32'(c_gnt | d_gnt), 32'h1);
      reset_n = 0;
      #1;
      chk("t5_gnt_in_rst", 32'({c_gnt, d_gnt, ram_en}), 32'h0);
      chk("t5_conf_in_rst", 32'(conflicts), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      reset_n = 1;
      @(posedge clk);
      #1;
      step();
      c_req = 1; d_req = 1;
      step();
      chk("t5_tie_core", 32'(e_c), 32'h1);

      // saturation of the 4-bit counter
      repeat (20) step();
      idle_inputs();
      step();
      chk("t6_sat", 32'(conflicts), 32'hF);

      // random traffic; requesters keep fields until granted
      do_reset();
      c_hold = 0; d_hold = 0;
      for (int i = 0; i < 400; i++) begin
         if (!c_hold) begin
            c_req = ($urandom_range(0, 2) != 0); c_we = $urandom_range(0, 1);
            c_addr = AW'($urandom); c_wdata = $urandom; c_wmask = 4'($urandom);
         end
         if (!d_hold) begin
            d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1);
            d_addr = AW'($urandom); d_wdata = $urandom; d_wmask = 4'($urandom);
         end
         if ($urandom_range(0, 7) == 0) d_lock = ~d_lock;
         ram_rdata = $urandom;
         step();
         c_hold = c_req && !e_c;
         d_hold = d_req && !e_d;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port block RAM between the core's memory interface and a debug/program-loader port.
- Issues at most one RAM access per cycle and grants requesters round-robin on contention.
- Supports a debug lock, so a loader can own memory for a multi-access sequence while the core is held off.
- Returns read data on the cycle after the grant, matching the RAM's registered output.

Parameters:
ADDR_W, 14, byte-address width of both requester ports; RAM word address is ADDR_W-2 bits.
CNT_W, 16, width of the saturating contention counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
c_req  in  1  core request.
c_we  in  1  core write (1) / read (0).
c_addr  in  ADDR_W  core byte address; bits [1:0] ignored.
c_wdata  in  32  core write data.
c_wmask  in  4  core byte-lane write enables.
c_gnt  out  1  core request accepted this cycle.
c_rvalid  out  1  core read data valid on c_rdata.
c_rdata  out  32  core read data.
d_req, d_we, d_addr, d_wdata, d_wmask  in  1/1/ADDR_W/32/4  debug port; same meaning as the core equivalents.
d_lock  in  1  debug holds ownership while high.
d_gnt, d_rvalid  out  1  debug grant and read-valid.
d_rdata  out  32  debug read data.
ram_en  out  1  RAM access this cycle.
ram_we  out  4  RAM byte write enables.
ram_addr  out  ADDR_W-2  RAM word address.
ram_wdata  out  32  RAM write data.
ram_rdata  in  32  RAM registered read data; valid the cycle after a read.
conflicts  out  CNT_W  count of cycles where both ports requested.

Behaviour:
- Request/grant:
  - A requester holds req and all request fields stable until it samples gnt=1.
  - gnt is combinational in the request cycle; a transfer completes on the cycle gnt=1.
  - At most one of c_gnt and d_gnt is high in any cycle.
- Registered state:
  - last_owner: 0 = core, 1 = debug.
  - FSM state: ARB or LOCKED.
  - rd_pend: 1 bit, plus rd_tag (owner of the pending read).
  - conflicts counter.
- ARB state:
  - One requester: it is granted.
  - Both requesting: grant the port that is not last_owner.
  - last_owner updates to the granted port at the clock edge.
- Entering LOCKED:
  - The transition ARB->LOCKED occurs when d_gnt=1 and d_lock=1.
- LOCKED state:
  - c_gnt is forced to 0.
  - d_req is granted every cycle it is asserted.
  - LOCKED->ARB on the first cycle d_lock=0 (sampled at the edge); that cycle is still arbitrated as LOCKED.
  - d_lock with no d_gnt in ARB has no effect.
- RAM drive:
  - On any grant: ram_en=1 and ram_addr=addr[ADDR_W-1:2] of the granted port.
  - Granted write: ram_we=wmask and ram_wdata=wdata.
  - Granted read: ram_we=0.
  - No grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Write with wmask=0 is granted with ram_en=1 and ram_we=0; it is a no-op.
- Read return:
  - A granted read sets rd_pend=1 and rd_tag=owner at the edge.
  - Next cycle, the matching x_rvalid=1 for exactly one cycle.
  - c_rdata and d_rdata are both driven from ram_rdata; they are meaningful only with rvalid.
  - Back-to-back reads are allowed: a grant in the rvalid cycle is legal, and rvalid may then be high in consecutive cycles, possibly alternating owners.
  - A write never produces rvalid.
- Conflict counter:
  - Increments when c_req and d_req are both high in a cycle, including LOCKED.
  - Saturates at all-ones.
- Reset (asynchronous assert, reset_n=0):
  - State=ARB, last_owner=debug (core wins the first tie), rd_pend=0, conflicts=0.
  - All grants, rvalids, ram_en and ram_we are 0.
  - Reset mid-read drops the pending read; no rvalid after release.
  - Deassertion is synchronous to clk, handled by the external reset synchroniser.

Test Plan:
1. Core-only read: c_req=1, c_we=0, c_addr=0x0010 -> same cycle c_gnt=1, ram_en=1, ram_addr=0x004, ram_we=0; next cycle c_rvalid=1, c_rdata=ram_rdata (0xDEADBEEF), d_rvalid=0.
2. Contention after reset: both req for 4 cycles -> grants core, debug, core, debug; conflicts=4; never both gnt high.
3. Lock: debug write granted with d_lock=1 at 0x0100, wmask=0xF, data 0x12345678 -> ram_we=0xF, ram_addr=0x040. Then with c_req held high for 3 cycles -> c_gnt=0 throughout while d_req grants each cycle. Drop d_lock -> one more LOCKED cycle, then the next contention grants the core.
4. Back-to-back reads alternating owners across cycles N and N+1 -> c_rvalid at N+1, d_rvalid at N+2, each exactly one cycle.
5. Reset mid-read: core read granted, reset_n=0 before the next edge -> no c_rvalid, conflicts=0, state ARB; the first post-reset tie grants the core.
6. Saturation with CNT_W=4: 20 contention cycles -> conflicts=0xF and holds.
